spi_slave_11: RTL and testbench
===============================

// Module: spi_slave_11
// PURPOSE
//  SPI responder, mode 3 (CPOL=1, CPHA=1), the far end of spi_master_11. One frame is 16 SCLK
//  cycles under ss_n low: an 8-bit address in on mosi, then an 8-bit read byte out on miso.
//  Address goes to a local register-read port; the returned byte is shifted back MSB first.
//  Sits behind the device pins in the peripheral/sensor-emulation side of the design.
// PARAMETERS
//  SYNC_STAGES  2  flops in synchronizers for sclk/ss_n/mosi (>=2)
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  asynchronous, active-low reset (0 = reset)
//  sclk        in   1  SPI clock from master, async to clk, idles high
//  ss_n        in   1  slave select, active low, async to clk
//  mosi        in   1  serial data from master, async to clk
//  miso        out  1  serial data to master
//  rd_addr     out  8  received address
//  rd_req      out  1  one-clk pulse: rd_addr valid, read requested
//  rd_data     in   8  read data; must be valid exactly 1 clk after rd_req
//  busy        out  1  high while a frame is in progress
//  done        out  1  one-clk pulse: all 16 bits completed
//  abort       out  1  one-clk pulse: ss_n rose before bit 16
// BEHAVIOUR
//  Reset (rst=0): state IDLE, miso=1, rd_addr=0, rd_req=0, busy=0, done=0, abort=0,
//   shift regs and bit counter =0. Async assert, sync deassert assumed from system reset.
//  Inputs pass SYNC_STAGES flops; edge detect on synced sclk: rise = sample, fall = shift.
//  SCLK half-period must be >= SYNC_STAGES+2 clk cycles (spi_master_11 CLK_DIV>=8 at default).
//  States: IDLE -> ADDR on synced ss_n falling. ADDR -> LOAD after 8th sclk rise.
//   LOAD -> DATA after 1 clk. DATA -> DONE after 16th sclk rise.
//   DONE -> IDLE on ss_n high. Any state except IDLE -> IDLE on ss_n high.
//  ADDR: each sclk rise shifts mosi into addr shift reg, MSB first, bit_cnt++ (4-bit).
//   miso held 1. Falling edges ignored.
//  On 8th rise: rd_addr <= {shift[6:0],mosi}; rd_req=1 for exactly one clk.
//  LOAD: clk after rd_req, tx shift reg <= rd_data.
//  DATA: first sclk fall after LOAD drives miso=tx[7]; each later fall shifts left, miso=next
//   bit. bit_cnt++ on every rise; after 16th rise assert done 1 clk.
//  Byte returned = rd_data captured in LOAD; rd_data changes afterwards have no effect.
//  DONE: miso holds last bit. Extra sclk edges ignored (no counting, no wrap, no second rd_req).
//  ss_n high in IDLE/ADDR/LOAD/DATA (bit_cnt<16) -> abort=1 one clk, no done.
//   Exception: IDLE gives no abort.
//  On every return to IDLE: miso=1, bit_cnt=0. rd_addr keeps its last value.
//  busy=1 in ADDR/LOAD/DATA/DONE, 0 in IDLE; it drops the clk after synced ss_n goes high.
//  ss_n low with no sclk activity: stays in ADDR indefinitely, no timeout.
//  sclk edges while ss_n high are ignored.
//  done and abort are mutually exclusive. rd_req fires at most once per frame.
//  Back-to-back frames: ss_n high for >= SYNC_STAGES+1 clk between frames is sufficient.
// TESTING
//  1 Frame addr=0xB7, responder returns rd_data=0x5A -> rd_addr=0xB7, one rd_req,
//    master data=0x5A, one done.
//  2 Frame addr=0xED, rd_data=0x3C, then immediate 2nd frame addr=0x01, rd_data=0xFF ->
//    rd_addr=0xED then 0x01, master receives 0x3C then 0xFF, two done pulses.
//  3 ss_n raised after 5 address bits -> abort=1 one clk, no rd_req, busy=0, miso=1,
//    next full frame (addr 0x80, rd_data 0xA5) returns 0xA5.
//  4 ss_n raised after 11 bits -> abort, no done; following frame unaffected.
//  5 rst=0 mid DATA phase -> all outputs at reset values within 1 clk; after release,
//    frame addr=0x42, rd_data=0x99 returns 0x99.
//  6 Four extra sclk cycles after bit 16 with ss_n still low -> no extra rd_req/done,
//    miso stable, busy=1 until ss_n high.

Source files
------------

// File: rtl/spi_slave_11.sv
// SPI mode-3 responder: receives an 8-bit address, issues a register read,
// and shifts the returned byte back on miso, all in the clk domain.
module spi_slave_11 #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   output logic [7:0] rd_addr,
   output logic       rd_req,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       abort
);

   typedef enum logic [2:0] {IDLE, ADDR, LOAD, DATA, DONE} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic       sclk_s, ss_s, mosi_s;
   logic       sclk_prev, ss_prev;
   logic       rise, fall, ss_fall;
   logic       rd_req_nxt, done_nxt, abort_nxt;
   logic [3:0] bit_cnt;
   logic [7:0] addr_sr, tx_sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync <= '1;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b1;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_prev <= sclk_s;
         ss_prev   <= ss_s;
      end
   end

   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign ss_s    = ss_sync[SYNC_STAGES-1];
   assign mosi_s  = mosi_sync[SYNC_STAGES-1];
   assign rise    = sclk_s & ~sclk_prev;
   assign fall    = ~sclk_s & sclk_prev;
   assign ss_fall = ~ss_s & ss_prev;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ADDR lingers one clk with rd_req high so LOAD sees rd_data one clk after the request
   always_comb begin
      state_nxt  = state;
      rd_req_nxt = 1'b0;
      done_nxt   = 1'b0;
      abort_nxt  = 1'b0;
      case (state)
         IDLE: if (ss_fall) state_nxt = ADDR;
         ADDR: begin
            if (rd_req) state_nxt = LOAD;
            else if (rise && bit_cnt == 4'd7) rd_req_nxt = 1'b1;
         end
         LOAD: state_nxt = DATA;
         DATA: begin
            if (rise && bit_cnt == 4'd15) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end
         end
         DONE: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && ss_s) begin
         state_nxt  = IDLE;
         rd_req_nxt = 1'b0;
         done_nxt   = 1'b0;
         abort_nxt  = (state != DONE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miso    <= 1'b1;
         rd_addr <= '0;
         rd_req  <= 1'b0;
         done    <= 1'b0;
         abort   <= 1'b0;
         bit_cnt <= '0;
         addr_sr <= '0;
         tx_sr   <= '0;
      end else begin
         rd_req <= rd_req_nxt;
         done   <= done_nxt;
         abort  <= abort_nxt;
         if (state_nxt == IDLE) begin
            miso    <= 1'b1;
            bit_cnt <= '0;
         end else begin
            case (state)
               ADDR: begin
                  if (rise && !rd_req) begin
                     addr_sr <= {addr_sr[6:0], mosi_s};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) rd_addr <= {addr_sr[6:0], mosi_s};
                  end
               end
               LOAD: tx_sr <= rd_data;
               DATA: begin
                  if (rise && bit_cnt != 4'd15) bit_cnt <= bit_cnt + 4'd1;
                  if (fall) begin
                     miso  <= tx_sr[7];
                     tx_sr <= {tx_sr[6:0], 1'b0};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_11.sv
// Bench for spi_slave_11: a bit-level SPI master and a one-clk-latency register
// responder drive frames; results are compared against frame-level expectations.
module tb_spi_slave_11;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst, sclk, ss_n, mosi;
   logic       miso, rd_req, busy, done, abort;
   logic [7:0] rd_addr;
   logic [7:0] rd_data = '0;
   logic [7:0] resp_byte = '0;
   logic       req_d = 1'b0;
   logic [7:0] model_addr = '0;

   int n_checks = 0, n_fail = 0;
   int cnt_req = 0, cnt_done = 0, cnt_abort = 0, cnt_both = 0;

   always #5 clk = ~clk;

   spi_slave_11 #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data),
      .busy(busy), .done(done), .abort(abort)
   );

   always @(posedge clk) begin
      if (rd_req) cnt_req++;
      if (done) cnt_done++;
      if (abort) cnt_abort++;
      if (done && abort) cnt_both++;
   end

   // Read port: data valid only in the clk following rd_req, garbage otherwise
   always @(posedge clk) begin
      #1;
      rd_data = req_d ? resp_byte : 8'($urandom);
      req_d = rd_req;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic frame(input logic [7:0] addr, input logic [7:0] data, input int nbits,
                        input int extra, input bit keep_ss, input int gap);
      int r0, d0, a0;
      logic [7:0] rx;
      r0 = cnt_req; d0 = cnt_done; a0 = cnt_abort;
      rx = '0;
      resp_byte = data;
      @(negedge clk);
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = (i < 8) ? addr[7-i] : 1'($urandom);
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         if (i >= 8) rx[15-i] = miso;
         repeat (HALF) @(negedge clk);
      end
      for (int e = 0; e < extra; e++) begin
         sclk = 1'b0;
         mosi = 1'($urandom);
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         check("miso_hold", {31'd0, miso}, {31'd0, data[0]});
         repeat (HALF) @(negedge clk);
      end
      if (nbits >= 8) model_addr = addr;
      if (keep_ss) return;
      if (extra > 0) check("busy_held", {31'd0, busy}, 32'd1);
      ss_n = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
      check("rd_req_cnt", cnt_req - r0, (nbits >= 8) ? 1 : 0);
      check("done_cnt", cnt_done - d0, (nbits == 16) ? 1 : 0);
      check("abort_cnt", cnt_abort - a0, (nbits < 16) ? 1 : 0);
      check("rd_addr", {24'd0, rd_addr}, {24'd0, model_addr});
      if (nbits == 16) check("rx_byte", {24'd0, rx}, {24'd0, data});
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("miso_idle", {31'd0, miso}, 32'd1);
      check("done_abort_excl", cnt_both, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int a0, d0, nb, ex, gp;
      rst = 1'b0; sclk = 1'b1; ss_n = 1'b1; mosi = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_miso", {31'd0, miso}, 32'd1);
      check("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
      check("rst_rd_req", {31'd0, rd_req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_abort", {31'd0, abort}, 32'd0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      frame(8'hB7, 8'h5A, 16, 0, 1'b0, 8);
      frame(8'hED, 8'h3C, 16, 0, 1'b0, 4);
      frame(8'h01, 8'hFF, 16, 0, 1'b0, 8);
      frame(8'h6E, 8'h11, 5, 0, 1'b0, 8);
      frame(8'h80, 8'hA5, 16, 0, 1'b0, 8);
      frame(8'hC3, 8'h0F, 11, 0, 1'b0, 8);
      frame(8'h24, 8'hE1, 16, 0, 1'b0, 8);

      frame(8'h3C, 8'h77, 12, 0, 1'b1, 8);
      a0 = cnt_abort; d0 = cnt_done;
      rst = 1'b0;
      #2;
      model_addr = '0;
      check("mid_rst_miso", {31'd0, miso}, 32'd1);
      check("mid_rst_rd_addr", {24'd0, rd_addr}, 32'd0);
      check("mid_rst_rd_req", {31'd0, rd_req}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_abort", {31'd0, abort}, 32'd0);
      ss_n = 1'b1; sclk = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_no_abort", cnt_abort - a0, 0);
      check("rst_no_done", cnt_done - d0, 0);
      frame(8'h42, 8'h99, 16, 0, 1'b0, 8);

      frame(8'h5D, 8'hC6, 16, 4, 1'b0, 8);

      for (int k = 0; k < 20; k++) begin
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
         ex = (nb == 16) ? int'($urandom_range(0, 2)) : 0;
         gp = int'($urandom_range(4, 8));
         frame(8'($urandom), 8'($urandom), nb, ex, 1'b0, gp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
